operand_stack: RTL and testbench
================================

// Module: operand_stack
// PURPOSE
//  Parametrised LIFO operand store for the calculator datapath; successor to the
//  single 8-bit operand register. Holds up to DEPTH operands of WIDTH bits.
//  Presents the top two entries to the ALU and supports push, pop and replace.
//  Flags overflow/underflow and supports a synchronous clear. Sits between
//  keypad/parse logic (producer) and the ALU (consumer of top/nxt, producer of result).
// PARAMETERS
//  WIDTH  16  operand width in bits (>=1)
//  DEPTH  4   number of stack entries (>=2)
//  CW     $clog2(DEPTH+1)  derived localparam, width of count
// PORTS
//  clk    in   1      rising-edge clock; single clock domain
//  rst    in   1      reset, asynchronous, active-high
//  d      in   WIDTH  operand to push/replace
//  push   in   1      push strobe, sampled on clk
//  pop    in   1      pop strobe, sampled on clk
//  clr    in   1      synchronous clear of stack and sticky flags
//  top    out  WIDTH  entry at count-1 (0 when empty)
//  nxt    out  WIDTH  entry at count-2 (0 when count<2)
//  count  out  CW     number of valid entries, 0..DEPTH
//  empty  out  1      count==0
//  full   out  1      count==DEPTH
//  ovf    out  1      sticky: push attempted while full
//  unf    out  1      sticky: pop attempted while empty
// BEHAVIOUR
//  - rst asserted: immediately (no clk needed) all entries, top, nxt, count, ovf,
//    unf = 0; empty=1, full=0. Reset overrides every strobe, incl. mid-sequence.
//  - All outputs registered; effect of a strobe visible the cycle after the edge.
//  - Per-edge priority: clr > (push&pop) > push > pop > idle.
//  - clr: entries, count, ovf, unf cleared; push/pop same cycle ignored.
//  - push&pop (replace): count>0 -> entry[count-1]=d, count unchanged;
//    count==0 -> behaves as plain push (count=1, top=d), unf not set.
//  - push: count<DEPTH -> entry[count]=d, count+1. count==DEPTH -> no change,
//    ovf<=1.
//  - pop: count>0 -> count-1; vacated entry cleared to 0. count==0 -> no change,
//    unf<=1.
//  - ovf/unf remain set until clr or rst; they never block further valid ops.
//  - Data stored unmodified; no arithmetic, no sign handling; d is exactly WIDTH.
//  - top/nxt derived from entries after the update, so ALU sees new operands
//    one cycle after the strobe; result writeback uses replace or pop-then-replace.
//  - count never exceeds DEPTH and never wraps below 0.
// STRUCTURE
//  - Shared package calc_pkg: default OPERAND_W, STACK_DEPTH constants and the
//    stack_op_e enum (IDLE, PUSH, POP, REPL, CLR) used by controller and bench.
//  - Sub-module op_reg: WIDTH-bit register with write enable, sync clear,
//    async active-high rst; instantiated DEPTH times via generate.
//  - Top level: priority decode to stack_op_e, count register, per-entry
//    write-enable/clear decode, top/nxt output registers, sticky flag registers.
// TESTING  (WIDTH=8, DEPTH=4)
//  - rst pulse mid-cycle with push held -> outputs 0, empty=1 before next edge.
//  - push 0x11,0x22,0x33 -> count=3, top=0x33, nxt=0x22, full=0.
//  - fill to 4, push 0x55 -> count=4, top unchanged, ovf=1; pop -> count=3, ovf=1.
//  - empty stack, pop -> unf=1, count=0; then push&pop d=0x7A -> count=1, top=0x7A.
//  - stack {0x11,0x22}, push&pop d=0x99 -> count=2, top=0x99, nxt=0x11.
//  - clr with push asserted same cycle -> count=0, ovf=unf=0, top=nxt=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand stack: default sizes,
// the stack operation encoding and the strobe priority decode.
package calc_pkg;

  localparam int OPERAND_W   = 16;
  localparam int STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP,
    REPL,
    CLR
  } stack_op_e;

  // Clear beats everything; push and pop together mean replace-top.
  function automatic stack_op_e decode_op(input logic clr, input logic push,
                                          input logic pop);
    if (clr)              return CLR;
    else if (push && pop) return REPL;
    else if (push)        return PUSH;
    else if (pop)         return POP;
    else                  return IDLE;
  endfunction

endpackage

// File: rtl/op_reg.sv
// One stack entry: WIDTH-bit register with write enable and synchronous clear.
module op_reg
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: storage is reset too, so a stale operand can never reappear at top/nxt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      // NOTE: sequential state always uses <= so every register samples pre-edge values.
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/operand_stack.sv
// LIFO operand store for the calculator datapath: push, pop, replace-top and
// clear, with registered top/nxt views for the ALU and sticky overflow/underflow.
module operand_stack
  import calc_pkg::*;
#(
  parameter  int WIDTH = OPERAND_W,
  parameter  int DEPTH = STACK_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1)
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] nxt,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  stack_op_e        op;
  logic [CW-1:0]    count_n;
  logic [DEPTH-1:0] we;
  logic [DEPTH-1:0] wclr;
  logic             ovf_n;
  logic             unf_n;
  logic [WIDTH-1:0] ent   [DEPTH];
  logic [WIDTH-1:0] ent_n [DEPTH];
  logic [WIDTH-1:0] top_n;
  logic [WIDTH-1:0] nxt_n;

  assign op = decode_op(clr, push, pop);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches.
    count_n = count;
    we      = '0;
    wclr    = '0;
    ovf_n   = ovf;
    unf_n   = unf;
    unique case (op)
      CLR: begin
        count_n = '0;
        wclr    = '1;
        ovf_n   = 1'b0;
        unf_n   = 1'b0;
      end
      REPL: begin
        if (count == '0) begin
          we[0]   = 1'b1;
          count_n = ONE;
        end else begin
          for (int i = 0; i < DEPTH; i++)
            if (CW'(i) == count - ONE) we[i] = 1'b1;
        end
      end
      PUSH: begin
        if (count == DEPTH_C) begin
          ovf_n = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++)
            if (CW'(i) == count) we[i] = 1'b1;
          count_n = count + ONE;
        end
      end
      POP: begin
        if (count == '0) begin
          unf_n = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++)
            if (CW'(i) == count - ONE) wclr[i] = 1'b1;
          count_n = count - ONE;
        end
      end
      default: ;
    endcase
  end

  // Mirror the entry update so top/nxt can be registered from post-update values.
  always_comb begin
    top_n = '0;
    nxt_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_n[i] = wclr[i] ? '0 : (we[i] ? d : ent[i]);
      if (CW'(i + 1) == count_n) top_n = ent_n[i];
      if ((i + 2 <= DEPTH) && (CW'(i + 2) == count_n)) nxt_n = ent_n[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    op_reg #(.WIDTH(WIDTH)) u_entry (
      .clk (clk),
      .rst (rst),
      .we  (we[g]),
      .clr (wclr[g]),
      .d   (d),
      .q   (ent[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      top   <= '0;
      nxt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= count_n;
      top   <= top_n;
      nxt   <= nxt_n;
      empty <= (count_n == '0);
      full  <= (count_n == DEPTH_C);
      ovf   <= ovf_n;
      unf   <= unf_n;
    end
  end

endmodule

// File: tb/tb_operand_stack.sv
// Directed scoreboard bench for operand_stack (WIDTH=8, DEPTH=4): the driver
// queues hand-computed expectations, a negedge monitor pops and compares them.
module tb_operand_stack;
  import calc_pkg::*;

  localparam int W  = 8;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  typedef struct {
    string          name;
    int             due;
    logic [W-1:0]   top;
    logic [W-1:0]   nxt;
    logic [CW-1:0]  count;
    logic           empty;
    logic           full;
    logic           ovf;
    logic           unf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  d;
  logic          push;
  logic          pop;
  logic          clr;
  logic [W-1:0]  top;
  logic [W-1:0]  nxt;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          unf;

  exp_t exp_q[$];
  int   cyc          = 0;
  int   n_vectors    = 0;
  int   n_miscompare = 0;

  operand_stack #(.WIDTH(W), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .push  (push),
    .pop   (pop),
    .clr   (clr),
    .top   (top),
    .nxt   (nxt),
    .count (count),
    .empty (empty),
    .full  (full),
    .ovf   (ovf),
    .unf   (unf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_now(input string name, input int due,
                            input logic [W-1:0] et, input logic [W-1:0] en,
                            input logic [CW-1:0] ec, input logic ee,
                            input logic ef, input logic eo, input logic eu);
    exp_t e;
    e.name = name; e.due = due;
    e.top = et; e.nxt = en; e.count = ec;
    e.empty = ee; e.full = ef; e.ovf = eo; e.unf = eu;
    exp_q.push_back(e);
  endtask

  // Apply one operation at the negedge; its effect is due after the next posedge.
  // For CLR, 'also' additionally raises push and pop in the same cycle.
  task automatic step(input string name, input stack_op_e op, input logic also,
                      input logic [W-1:0] dv,
                      input logic [W-1:0] et, input logic [W-1:0] en,
                      input logic [CW-1:0] ec, input logic ee, input logic ef,
                      input logic eo, input logic eu);
    @(negedge clk);
    d    = dv;
    push = (op == PUSH) || (op == REPL) || (op == CLR && also);
    pop  = (op == POP)  || (op == REPL) || (op == CLR && also);
    clr  = (op == CLR);
    expect_now(name, cyc + 1, et, en, ec, ee, ef, eo, eu);
  endtask

  // Monitor: compare every expectation whose due cycle has been reached.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        n_vectors++;
        if ({top, nxt, count, empty, full, ovf, unf} !==
            {e.top, e.nxt, e.count, e.empty, e.full, e.ovf, e.unf}) begin
          n_miscompare++;
          $display("FAIL %s: got top=%h nxt=%h count=%0d empty=%b full=%b ovf=%b unf=%b, want top=%h nxt=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
                   e.name, top, nxt, count, empty, full, ovf, unf,
                   e.top, e.nxt, e.count, e.empty, e.full, e.ovf, e.unf);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; d = '0; push = 1'b0; pop = 1'b0; clr = 1'b0;
    expect_now("reset_state", 0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    //   name            op    also d      top    nxt    cnt  e     f     o     u
    step("push_11",      PUSH, 1'b0, 8'h11, 8'h11, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("push_22",      PUSH, 1'b0, 8'h22, 8'h22, 8'h11, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step("push_33",      PUSH, 1'b0, 8'h33, 8'h33, 8'h22, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("push_44_full", PUSH, 1'b0, 8'h44, 8'h44, 8'h33, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    step("push_55_ovf",  PUSH, 1'b0, 8'h55, 8'h44, 8'h33, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    step("pop_after_ovf", POP, 1'b0, 8'h00, 8'h33, 8'h22, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset pulse in the middle of a cycle while push is held.
    @(negedge clk);
    d = 8'h66; push = 1'b1; pop = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    expect_now("rst_mid_cycle", cyc, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;

    step("idle_after_rst", IDLE, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("pop_empty_unf",  POP,  1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("repl_empty_7a",  REPL, 1'b0, 8'h7A, 8'h7A, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("pop_to_empty",   POP,  1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("clr_flags",      CLR,  1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("push_11_b",      PUSH, 1'b0, 8'h11, 8'h11, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("push_22_b",      PUSH, 1'b0, 8'h22, 8'h22, 8'h11, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step("repl_99",        REPL, 1'b0, 8'h99, 8'h99, 8'h11, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step("push_a5",        PUSH, 1'b0, 8'hA5, 8'hA5, 8'h99, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("pop_to_2",       POP,  1'b0, 8'h00, 8'h99, 8'h11, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step("pop_to_1",       POP,  1'b0, 8'h00, 8'h11, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("push_3c",        PUSH, 1'b0, 8'h3C, 8'h3C, 8'h11, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step("push_5a",        PUSH, 1'b0, 8'h5A, 8'h5A, 8'h3C, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("push_6b_full",   PUSH, 1'b0, 8'h6B, 8'h6B, 8'h5A, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    step("push_ff_ovf",    PUSH, 1'b0, 8'hFF, 8'h6B, 8'h5A, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    step("repl_full_77",   REPL, 1'b0, 8'h77, 8'h77, 8'h5A, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    step("pop_from_full",  POP,  1'b0, 8'h00, 8'h5A, 8'h3C, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step("push_88_refill", PUSH, 1'b0, 8'h88, 8'h88, 8'h5A, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    step("clr_with_pp",    CLR,  1'b1, 8'hEE, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("push_01_post",   PUSH, 1'b0, 8'h01, 8'h01, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle_hold",      IDLE, 1'b0, 8'hC3, 8'h01, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_miscompare++;
      $display("FAIL drain_timeout: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
    $finish;
  end

endmodule
